// File: rtl/hilo_acc_reg_if.sv
// rtl/hilo_acc_reg_if.sv - HI/LO unit bus: direct writes, accumulate request, register outputs
interface hilo_acc_reg_if #(
  parameter int WIDTH = 32
);
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             acc_valid;
  logic             acc_signed;
  logic             acc_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy;
  logic             done;

  modport master (
    output we_hi, we_lo, hi_i, lo_i, acc_valid, acc_signed, acc_sub, op_a, op_b,
    input  hi_o, lo_o, busy, done
  );

  modport slave (
    input  we_hi, we_lo, hi_i, lo_i, acc_valid, acc_signed, acc_sub, op_a, op_b,
    output hi_o, lo_o, busy, done
  );
endinterface

// File: rtl/hilo_acc_reg.sv
// rtl/hilo_acc_reg.sv - MIPS32 HI/LO registers with multi-cycle multiply-accumulate
module hilo_acc_reg #(
  parameter int WIDTH  = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  hilo_acc_reg_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               sgn_q;
  logic               sub_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] hilo;
  logic [2*WIDTH-1:0] acc_d;

  // A 2W x 2W product truncated to 2W bits is exact for both signed and unsigned operands.
  assign ext_a  = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign ext_b  = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign prod_d = ext_a * ext_b;
  assign hilo   = {hi_q, lo_q};
  assign acc_d  = sub_q ? (hilo - prod_q) : (hilo + prod_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      sgn_q  <= 1'b0;
      sub_q  <= 1'b0;
      done_q <= 1'b0;
      prod_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.we_hi) hi_q <= bus.hi_i;
          if (bus.we_lo) lo_q <= bus.lo_i;
          // Operands are captured now; the accumulate reads HI/LO two edges later,
          // so it naturally sees any direct write made in this same cycle.
          if (bus.acc_valid && ACC_EN) begin
            opa_q <= bus.op_a;
            opb_q <= bus.op_b;
            sgn_q <= bus.acc_signed;
            sub_q <= bus.acc_sub;
            state <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_d;
          state  <= ACC;
        end
        ACC: begin
          {hi_q, lo_q} <= acc_d;
          done_q       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
  assign bus.busy = ACC_EN && (state != IDLE);
  assign bus.done = ACC_EN && done_q;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// tb/tb_hilo_acc_reg.sv - directed scoreboard bench for hilo_acc_reg
module tb_hilo_acc_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model;

  hilo_acc_reg_if #(.WIDTH(W)) bus ();

  hilo_acc_reg #(.WIDTH(W), .ACC_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we_hi      = 1'b0;
    bus.we_lo      = 1'b0;
    bus.hi_i       = '0;
    bus.lo_i       = '0;
    bus.acc_valid  = 1'b0;
    bus.acc_signed = 1'b0;
    bus.acc_sub    = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
  endtask

  function automatic logic [63:0] mac(input logic [63:0] h, input bit s, input bit sub,
                                      input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return sub ? (h - p) : (h + p);
  endfunction

  // Issues one accumulate from the current cycle; returns in the cycle done is seen.
  task automatic do_acc(input bit s, input bit sub, input logic [31:0] a, input logic [31:0] b,
                        input bit junk, input string tag);
    int cyc;
    logic [63:0] e;
    bus.acc_valid  = 1'b1;
    bus.acc_signed = s;
    bus.acc_sub    = sub;
    bus.op_a       = a;
    bus.op_b       = b;
    model = mac(model, s, sub, a, b);
    sb_q.push_back(model);
    step();
    bus.acc_valid = 1'b0;
    bus.we_hi     = 1'b0;
    bus.we_lo     = 1'b0;
    if (junk) begin
      bus.we_hi     = 1'b1;
      bus.hi_i      = 32'hAAAA0000;
      bus.acc_valid = 1'b1;
    end
    check({tag, "_busy"}, {63'b0, bus.busy}, 64'd1);
    check({tag, "_nodone"}, {63'b0, bus.done}, 64'd0);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 8) begin
      step();
      cyc++;
    end
    bus.we_hi     = 1'b0;
    bus.acc_valid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd2);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, e);
    end else begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end
    check({tag, "_busy_low"}, {63'b0, bus.busy}, 64'd0);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.we_hi = 1'b1;
    bus.we_lo = 1'b1;
    bus.hi_i  = h;
    bus.lo_i  = l;
    step();
    idle_inputs();
    model = {h, l};
  endtask

  initial begin
    int extra;
    idle_inputs();
    model = '0;

    rst = 1'b0;
    bus.we_hi = 1'b1;
    bus.we_lo = 1'b1;
    bus.hi_i  = 32'hFFFFFFFF;
    bus.lo_i  = 32'hFFFFFFFF;
    step();
    step();
    check("rst_hi", {32'b0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'b0, bus.lo_o}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);

    rst = 1'b1;
    bus.we_hi = 1'b1;
    bus.we_lo = 1'b0;
    bus.hi_i  = 32'h12345678;
    bus.lo_i  = 32'hDEADBEEF;
    step();
    check("wr_hi", {32'b0, bus.hi_o}, 64'h12345678);
    check("wr_lo", {32'b0, bus.lo_o}, 64'h0);
    idle_inputs();

    write_hilo(32'h0, 32'h10);
    do_acc(1'b1, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b0, "madd");
    check("madd_const", {bus.hi_o, bus.lo_o}, 64'h0000_0000_0000_000A);
    step();
    check("madd_done_once", {63'b0, bus.done}, 64'd0);

    write_hilo(32'h0, 32'h0);
    do_acc(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "msubu");
    check("msubu_const", {bus.hi_o, bus.lo_o}, 64'h0000_0001_FFFF_FFFF);
    step();

    write_hilo(32'h0, 32'h0);
    bus.we_lo = 1'b1;
    bus.lo_i  = 32'd5;
    model     = 64'd5;
    do_acc(1'b1, 1'b0, 32'd2, 32'd3, 1'b0, "collide");
    check("collide_lo", {32'b0, bus.lo_o}, 64'h0000000B);

    do_acc(1'b1, 1'b0, 32'd1, 32'd1, 1'b1, "busy_ign");
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done === 1'b1) extra++;
    end
    check("busy_ign_one_done", 64'(extra), 64'd0);
    check("busy_ign_hi", {32'b0, bus.hi_o}, 64'd0);

    do_acc(1'b0, 1'b0, 32'd7, 32'd8, 1'b0, "b2b_first");
    do_acc(1'b1, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b0, "b2b_second");
    step();
    check("b2b_done_low", {63'b0, bus.done}, 64'd0);

    bus.acc_valid  = 1'b1;
    bus.acc_signed = 1'b1;
    bus.acc_sub    = 1'b0;
    bus.op_a       = 32'd2;
    bus.op_b       = 32'd3;
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done === 1'b1) extra++;
    end
    check("abort_no_done", 64'(extra), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_acc_reg.md
Name: hilo_acc_reg

Overview:
- Parametrised HI/LO special-register unit for the execute/write-back boundary of the MIPS32 pipeline.
- Holds HI and LO as independently writable registers for MTHI/MTLO and MULT/DIV write-back.
- Adds a multi-cycle multiply-accumulate path (MADD/MADDU/MSUB/MSUBU): it multiplies two operands and adds or subtracts the product from {HI,LO}.
- Raises busy so the pipeline control stalls while an accumulate is in flight.

Parameters:
- WIDTH, 32, width of HI, LO and each multiply operand; product and {HI,LO} are 2*WIDTH.
- ACC_EN, 1, 1 = accumulate path present; 0 = acc_valid ignored, busy and done tied 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- we_hi  input  1  direct write enable for HI.
- we_lo  input  1  direct write enable for LO.
- hi_i  input  WIDTH  direct write data for HI.
- lo_i  input  WIDTH  direct write data for LO.
- acc_valid  input  1  request to start an accumulate; accepted only in IDLE.
- acc_signed  input  1  1 = signed multiply (MADD/MSUB); 0 = unsigned (MADDU/MSUBU).
- acc_sub  input  1  1 = {HI,LO} minus product; 0 = {HI,LO} plus product.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- hi_o  output  WIDTH  registered HI.
- lo_o  output  WIDTH  registered LO.
- busy  output  1  high while the FSM is in MUL or ACC.
- done  output  1  one-cycle pulse, high in the cycle the accumulate result first appears on hi_o/lo_o.

Behaviour:
- Reset (rst=0 at an edge):
  - hi_o=0, lo_o=0, state=IDLE, busy=0, done=0.
  - Internal operand, product and op registers are cleared.
  - Reset overrides every other input.
- FSM states: IDLE, MUL, ACC. busy = (state != IDLE), decoded from the registered state.
- IDLE:
  - we_hi=1 loads hi_i into HI at the edge; we_lo=1 loads lo_i into LO at the edge. The two enables are independent.
  - If acc_valid=1 (and ACC_EN=1), op_a, op_b, acc_signed and acc_sub are latched and the FSM goes to MUL.
  - A direct write in the same cycle is still applied. The accumulate then uses the post-write {HI,LO}.
- MUL (one cycle):
  - Forms the 2*WIDTH product of the latched operands: sign-extended if acc_signed=1, zero-extended otherwise.
  - Registers the product and goes to ACC.
- ACC (one cycle):
  - {HI,LO} <= {HI,LO} + product, or minus product if acc_sub=1.
  - Arithmetic is modulo 2^(2*WIDTH); no overflow detection or trap.
  - Goes to IDLE and sets done=1 for the following cycle.
- Latency: acc accepted at edge N; result visible on hi_o/lo_o and done=1 after edge N+2. done returns to 0 after edge N+3.
- While busy=1:
  - we_hi, we_lo and acc_valid are ignored.
  - Upstream must hold the instruction until busy falls.
  - A new accumulate can be accepted in the cycle done=1 (back-to-back issue, 3 cycles per op).
- Reset mid-operation (MUL or ACC): aborts to IDLE, clears HI/LO, no done pulse.
- ACC_EN=0: the unit behaves as a plain dual-enable HI/LO register, with busy=0 and done=0 constant.

Test Plan:
- Reset: drive rst=0 for 2 cycles with we_hi=we_lo=1, hi_i=lo_i=0xFFFFFFFF -> hi_o=0, lo_o=0, busy=0, done=0.
- Independent write: from hilo=0, we_hi=1, we_lo=0, hi_i=0x12345678, lo_i=0xDEADBEEF -> after one edge hi_o=0x12345678, lo_o=0x00000000.
- Signed MADD:
  - Setup: hilo=0x00000000_00000010, acc_valid=1, acc_signed=1, acc_sub=0, op_a=0xFFFFFFFE (-2), op_b=3.
  - Required: busy=1 for 2 cycles, then hilo=0x00000000_0000000A with done=1 for exactly one cycle.
- Unsigned MSUBU wrap:
  - Setup: hilo=0, acc_signed=0, acc_sub=1, op_a=op_b=0xFFFFFFFF.
  - Required: hilo=0x00000001_FFFFFFFF after 2 edges.
- Collisions:
  - In IDLE, we_lo=1, lo_i=5 together with signed MADD 2*3 from hilo=0 -> final lo_o=0x0000000B.
  - During busy, we_hi=1, hi_i=0xAAAA0000 and acc_valid=1 -> both ignored; hi_o unchanged; only one done pulse.
- Reset mid-op: start MADD, assert rst=0 during MUL -> next cycle hilo=0, busy=0, and no done pulse follows.
